// File: rtl/dmem_load_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and UART boot loader:
// loader FSM encoding, system MMIO map and the default load address.
package dmem_load_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    localparam logic [31:0] MMIO_DIGITS    = 32'h4000_0010;
    localparam logic [31:0] MMIO_UART_TX   = 32'h4000_0018;
    localparam logic [31:0] MMIO_UART_RX   = 32'h4000_001C;
    localparam logic [31:0] MMIO_UART_CTRL = 32'h4000_0020;

    localparam logic [31:0] DEFAULT_LOAD_BASE = 32'h0000_0000;

    // Byte address of loaded word number idx.
    function automatic logic [31:0] load_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dmem_load_arbiter_ld_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_ready is a
// combinational strobe in the cycle the fourth byte arrives.
module ld_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  byte_idx;
    logic [23:0] shift_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_idx <= 2'd0;
            shift_q  <= 24'd0;
        end else if (clear) begin
            byte_idx <= 2'd0;
        end else if (byte_valid) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
                2'd0:    shift_q[7:0]   <= byte_in;
                2'd1:    shift_q[15:8]  <= byte_in;
                2'd2:    shift_q[23:16] <= byte_in;
                default: ;
            endcase
        end
    end

    // The top byte bypasses the shift register so the word is complete
    // on the same edge that accepts byte 3.
    assign word       = {byte_in, shift_q};
    assign word_ready = byte_valid && (byte_idx == 2'd3);

endmodule

// File: rtl/dmem_load_arbiter.sv
// Fixed-priority data-memory port arbiter: the CPU MEM stage always wins,
// the UART boot loader commits its pending word in otherwise idle cycles.
module dmem_load_arbiter
    import dmem_load_arbiter_pkg::*;
#(
    parameter logic [31:0] LOAD_BASE  = DEFAULT_LOAD_BASE,
    parameter int unsigned LOAD_WORDS = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_memrd,
    input  logic        cpu_memwr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wrdata,
    output logic [31:0] cpu_rddata,
    input  logic        ld_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wrdata,
    input  logic [31:0] mem_rddata,
    output logic        ld_busy,
    output logic        ld_done,
    output logic        ld_overrun,
    output logic [15:0] ld_words
);

    localparam logic [15:0] LAST_IDX = 16'(LOAD_WORDS - 1);

    logic [1:0]  state;
    logic        pending;
    logic [31:0] pend_word;
    logic [15:0] asm_cnt;
    logic [31:0] word;
    logic        word_ready;

    logic cpu_req, commit, start, byte_valid;

    assign cpu_req    = cpu_memrd | cpu_memwr;
    assign commit     = pending && !cpu_req;
    assign start      = ld_start && (state == ST_IDLE);
    assign byte_valid = rx_valid && (state == ST_RUN);
    assign ld_busy    = (state != ST_IDLE);

    ld_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start),
        .byte_valid (byte_valid),
        .byte_in    (rx_byte),
        .word       (word),
        .word_ready (word_ready)
    );

    // NOTE: the pending data register is reset along with its valid flag so
    // nothing stale can reach the RAM after a mid-session abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pending    <= 1'b0;
            pend_word  <= 32'd0;
            asm_cnt    <= 16'd0;
            ld_words   <= 16'd0;
            ld_done    <= 1'b0;
            ld_overrun <= 1'b0;
        end else begin
            ld_done <= 1'b0;
            if (commit) begin
                pending  <= 1'b0;
                ld_words <= ld_words + 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (ld_start) begin
                        state      <= ST_RUN;
                        pending    <= 1'b0;
                        asm_cnt    <= 16'd0;
                        ld_words   <= 16'd0;
                        ld_overrun <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (word_ready) begin
                        asm_cnt <= asm_cnt + 16'd1;
                        // A commit on this same edge frees the slot, so reload.
                        if (!pending || commit) begin
                            pending   <= 1'b1;
                            pend_word <= word;
                        end else begin
                            ld_overrun <= 1'b1;
                        end
                        if (asm_cnt == LAST_IDX)
                            state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (commit) begin
                        state   <= ST_IDLE;
                        ld_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: every output gets a default first so the mux cannot infer a latch.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = 32'd0;
        mem_wrdata = 32'd0;
        cpu_rddata = 32'd0;
        if (cpu_req) begin
            mem_rd     = cpu_memrd;
            mem_wr     = cpu_memwr;
            mem_addr   = cpu_addr;
            mem_wrdata = cpu_wrdata;
            cpu_rddata = mem_rddata;
        end else if (pending) begin
            mem_wr     = 1'b1;
            mem_addr   = load_addr(LOAD_BASE, ld_words);
            mem_wrdata = pend_word;
        end
    end

endmodule

// File: tb/tb_dmem_load_arbiter.sv
// Self-checking bench for dmem_load_arbiter: scenario tasks plus randomized
// load sessions checked against an expected word list and address map.
module tb_dmem_load_arbiter;

    localparam logic [31:0] BASE = 32'h0000_0200;
    localparam int          NW   = 4;

    logic        clk, rst;
    logic        cpu_memrd, cpu_memwr;
    logic [31:0] cpu_addr, cpu_wrdata, cpu_rddata;
    logic        ld_start, rx_valid;
    logic [7:0]  rx_byte;
    logic        mem_rd, mem_wr;
    logic [31:0] mem_addr, mem_wrdata, mem_rddata;
    logic        ld_busy, ld_done, ld_overrun;
    logic [15:0] ld_words;

    int asserts  = 0;
    int failures = 0;
    int arb_err  = 0;
    int done_cnt = 0;
    int done_after = -1;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    dmem_load_arbiter #(.LOAD_BASE(BASE), .LOAD_WORDS(NW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_memrd  (cpu_memrd),
        .cpu_memwr  (cpu_memwr),
        .cpu_addr   (cpu_addr),
        .cpu_wrdata (cpu_wrdata),
        .cpu_rddata (cpu_rddata),
        .ld_start   (ld_start),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .mem_rddata (mem_rddata),
        .ld_busy    (ld_busy),
        .ld_done    (ld_done),
        .ld_overrun (ld_overrun),
        .ld_words   (ld_words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) mem_rddata <= $urandom();

    // Port monitor: CPU gets a transparent path, otherwise only loader writes.
    always @(negedge clk) begin
        if (!rst) begin
            if (cpu_memrd || cpu_memwr) begin
                if (mem_rd !== cpu_memrd || mem_wr !== cpu_memwr || mem_addr !== cpu_addr ||
                    mem_wrdata !== cpu_wrdata || cpu_rddata !== mem_rddata) begin
                    arb_err++;
                    $display("arbitration error at %0t: cpu path not transparent", $time);
                end
            end else begin
                if (cpu_rddata !== 32'd0 || mem_rd !== 1'b0) begin
                    arb_err++;
                    $display("arbitration error at %0t: idle cpu sees rd/rddata", $time);
                end
                if (mem_wr === 1'b1) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wrdata);
                end else if (mem_wr !== 1'b0 || mem_addr !== 32'd0 || mem_wrdata !== 32'd0) begin
                    arb_err++;
                    $display("arbitration error at %0t: idle port not zero", $time);
                end
            end
            if (ld_done === 1'b1) begin
                done_cnt++;
                done_after = wr_addr_q.size();
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_idle();
        cpu_memrd  = 1'b0;
        cpu_memwr  = 1'b0;
        cpu_addr   = 32'd0;
        cpu_wrdata = 32'd0;
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cnt   = 0;
        done_after = -1;
    endtask

    task automatic start_session();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (ld_busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        asserts++;
        if (ld_busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: ld_busy=%b after %0d cycles, required 0", ld_busy, budget);
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cpu_idle();
        ld_start = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        asserts++;
        if ({mem_rd, mem_wr, mem_addr, mem_wrdata, cpu_rddata, ld_busy, ld_done, ld_overrun, ld_words} !== 117'd0) begin
            failures++;
            $display("FAIL reset_values: got rd=%b wr=%b addr=%h wd=%h rdd=%h busy=%b done=%b ovr=%b words=%0d, required all 0",
                     mem_rd, mem_wr, mem_addr, mem_wrdata, cpu_rddata, ld_busy, ld_done, ld_overrun, ld_words);
        end
        clear_log();
        start_session();
        send_word($urandom(), 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        asserts++;
        if (wr_addr_q.size() != 1) begin
            failures++;
            $display("FAIL reset_pre_abort_writes: got %0d writes, required 1", wr_addr_q.size());
        end
        #2 rst = 1'b1;
        #1;
        asserts++;
        if ({mem_rd, mem_wr, mem_addr, mem_wrdata, cpu_rddata, ld_busy, ld_done, ld_overrun, ld_words} !== 117'd0) begin
            failures++;
            $display("FAIL reset_async_abort: got wr=%b busy=%b words=%0d, required all 0", mem_wr, ld_busy, ld_words);
        end
        tick();
        tick();
        rst = 1'b0;
        clear_log();
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        repeat (6) tick();
        asserts++;
        if (wr_addr_q.size() != 0 || ld_busy !== 1'b0 || ld_words !== 16'd0) begin
            failures++;
            $display("FAIL reset_no_writes_after: got writes=%0d busy=%b words=%0d, required 0/0/0",
                     wr_addr_q.size(), ld_busy, ld_words);
        end
    endtask

    task automatic test_basic_load();
        logic [31:0] exp_w [NW];
        clear_log();
        start_session();
        asserts++;
        if (ld_busy !== 1'b1 || ld_words !== 16'd0 || ld_overrun !== 1'b0) begin
            failures++;
            $display("FAIL basic_start: got busy=%b words=%0d ovr=%b, required 1/0/0", ld_busy, ld_words, ld_overrun);
        end
        exp_w[0] = 32'h1234_5678;
        exp_w[1] = 32'hDEAD_BEEF;
        for (int i = 2; i < NW; i++) exp_w[i] = $urandom();
        for (int i = 0; i < NW; i++) send_word(exp_w[i], $urandom_range(1, 3));
        wait_idle(20);
        for (int i = 0; i < NW; i++) begin
            asserts++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL basic_word%0d: got %0d writes, required data %h @%h", i, wr_addr_q.size(), exp_w[i], BASE + 32'(4 * i));
            end
        end
        asserts++;
        if (wr_addr_q.size() != NW || ld_words !== 16'(NW) || done_cnt != 1 || done_after != NW) begin
            failures++;
            $display("FAIL basic_status: got writes=%0d words=%0d done=%0d done_after=%0d, required %0d/%0d/1/%0d",
                     wr_addr_q.size(), ld_words, done_cnt, done_after, NW, NW, NW);
        end
    endtask

    task automatic test_cpu_priority();
        logic [31:0] exp_w [NW];
        clear_log();
        arb_err = 0;
        for (int i = 0; i < NW; i++) exp_w[i] = $urandom();
        start_session();
        for (int k = 0; k < 3; k++) send_byte(exp_w[0][8*k +: 8], 1);
        rx_valid  = 1'b1;
        rx_byte   = exp_w[0][31:24];
        cpu_memrd = 1'b1;
        cpu_addr  = 32'h0000_0008;
        tick();
        rx_valid = 1'b0;
        repeat (10) tick();
        asserts++;
        if (wr_addr_q.size() != 0 || mem_rd !== 1'b1) begin
            failures++;
            $display("FAIL prio_deferred: got writes=%0d mem_rd=%b, required 0 writes and mem_rd=1", wr_addr_q.size(), mem_rd);
        end
        cpu_idle();
        @(negedge clk);
        asserts++;
        if (mem_wr !== 1'b1 || mem_addr !== BASE || mem_wrdata !== exp_w[0]) begin
            failures++;
            $display("FAIL prio_first_idle: got wr=%b %h @%h, required 1 %h @%h", mem_wr, mem_wrdata, mem_addr, exp_w[0], BASE);
        end
        tick();
        for (int i = 1; i < NW; i++) send_word(exp_w[i], 1);
        wait_idle(20);
        for (int i = 0; i < NW; i++) begin
            asserts++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== exp_w[i]) begin
                failures++;
                $display("FAIL prio_word%0d: got %0d writes, required data %h @%h", i, wr_addr_q.size(), exp_w[i], BASE + 32'(4 * i));
            end
        end
        asserts++;
        if (arb_err != 0) begin
            failures++;
            $display("FAIL prio_arbitration: got %0d port errors, required 0", arb_err);
        end
    endtask

    task automatic test_overrun();
        logic [31:0] w [NW];
        clear_log();
        for (int i = 0; i < NW; i++) w[i] = $urandom();
        start_session();
        cpu_memwr  = 1'b1;
        cpu_addr   = $urandom();
        cpu_wrdata = $urandom();
        send_word(w[0], 1);
        send_word(w[1], 1);
        cpu_idle();
        tick();
        asserts++;
        if (ld_overrun !== 1'b1 || ld_words !== 16'd1) begin
            failures++;
            $display("FAIL overrun_flag: got ovr=%b words=%0d, required 1/1", ld_overrun, ld_words);
        end
        send_word(w[2], 1);
        send_word(w[3], 1);
        wait_idle(20);
        for (int i = 0; i < 3; i++) begin
            asserts++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[(i == 0) ? 0 : i + 1]) begin
                failures++;
                $display("FAIL overrun_word%0d: got %0d writes, required data %h @%h",
                         i, wr_addr_q.size(), w[(i == 0) ? 0 : i + 1], BASE + 32'(4 * i));
            end
        end
        asserts++;
        if (wr_addr_q.size() != 3 || ld_words !== 16'd3 || done_cnt != 1 || done_after != 3 || ld_overrun !== 1'b1) begin
            failures++;
            $display("FAIL overrun_status: got writes=%0d words=%0d done=%0d ovr=%b, required 3/3/1/1",
                     wr_addr_q.size(), ld_words, done_cnt, ld_overrun);
        end
    endtask

    task automatic test_ignored();
        logic [31:0] w [NW];
        clear_log();
        for (int i = 0; i < NW; i++) w[i] = $urandom();
        send_word($urandom(), 1);
        repeat (3) tick();
        asserts++;
        if (wr_addr_q.size() != 0 || ld_busy !== 1'b0 || ld_words !== 16'd3 || ld_overrun !== 1'b1) begin
            failures++;
            $display("FAIL ignored_idle_rx: got writes=%0d busy=%b words=%0d ovr=%b, required 0/0/3/1",
                     wr_addr_q.size(), ld_busy, ld_words, ld_overrun);
        end
        ld_start = 1'b1;
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        tick();
        ld_start = 1'b0;
        rx_valid = 1'b0;
        tick();
        asserts++;
        if (ld_busy !== 1'b1 || ld_overrun !== 1'b0 || ld_words !== 16'd0) begin
            failures++;
            $display("FAIL ignored_start: got busy=%b ovr=%b words=%0d, required 1/0/0", ld_busy, ld_overrun, ld_words);
        end
        send_byte(w[0][7:0], 1);
        send_byte(w[0][15:8], 1);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        send_byte(w[0][23:16], 1);
        send_byte(w[0][31:24], 1);
        for (int i = 1; i < NW; i++) send_word(w[i], 1);
        wait_idle(20);
        for (int i = 0; i < NW; i++) begin
            asserts++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i]) begin
                failures++;
                $display("FAIL ignored_word%0d: got %0d writes, required data %h @%h", i, wr_addr_q.size(), w[i], BASE + 32'(4 * i));
            end
        end
        asserts++;
        if (done_cnt != 1 || ld_words !== 16'(NW)) begin
            failures++;
            $display("FAIL ignored_status: got done=%0d words=%0d, required 1/%0d", done_cnt, ld_words, NW);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w [NW];
        clear_log();
        for (int i = 0; i < NW; i++) w[i] = $urandom();
        start_session();
        cpu_memrd = 1'b1;
        cpu_addr  = $urandom();
        send_word(w[0], 1);
        for (int k = 0; k < 3; k++) send_byte(w[1][8*k +: 8], 1);
        rx_valid = 1'b1;
        rx_byte  = w[1][31:24];
        cpu_idle();
        @(negedge clk);
        asserts++;
        if (mem_wr !== 1'b1 || mem_addr !== BASE || mem_wrdata !== w[0]) begin
            failures++;
            $display("FAIL b2b_commit0: got wr=%b %h @%h, required 1 %h @%h", mem_wr, mem_wrdata, mem_addr, w[0], BASE);
        end
        tick();
        rx_valid = 1'b0;
        @(negedge clk);
        asserts++;
        if (mem_wr !== 1'b1 || mem_addr !== BASE + 32'd4 || mem_wrdata !== w[1] || ld_overrun !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reload: got wr=%b %h @%h ovr=%b, required 1 %h @%h ovr=0",
                     mem_wr, mem_wrdata, mem_addr, ld_overrun, w[1], BASE + 32'd4);
        end
        tick();
        send_word(w[2], 1);
        send_word(w[3], 1);
        wait_idle(20);
        for (int i = 0; i < NW; i++) begin
            asserts++;
            if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i]) begin
                failures++;
                $display("FAIL b2b_word%0d: got %0d writes, required data %h @%h", i, wr_addr_q.size(), w[i], BASE + 32'(4 * i));
            end
        end
        asserts++;
        if (ld_overrun !== 1'b0 || ld_words !== 16'(NW) || done_cnt != 1) begin
            failures++;
            $display("FAIL b2b_status: got ovr=%b words=%0d done=%0d, required 0/%0d/1", ld_overrun, ld_words, done_cnt, NW);
        end
    endtask

    task automatic test_random();
        logic [31:0] w [NW];
        int gap;
        for (int s = 0; s < 3; s++) begin
            clear_log();
            arb_err = 0;
            for (int i = 0; i < NW; i++) w[i] = $urandom();
            start_session();
            for (int i = 0; i < NW; i++) begin
                for (int k = 0; k < 4; k++) begin
                    cpu_memrd  = 1'($urandom_range(0, 1));
                    cpu_memwr  = 1'($urandom_range(0, 1));
                    cpu_addr   = $urandom();
                    cpu_wrdata = $urandom();
                    rx_valid   = 1'b1;
                    rx_byte    = w[i][8*k +: 8];
                    tick();
                    rx_valid = 1'b0;
                    gap = $urandom_range(1, 4);
                    for (int j = 0; j < gap; j++) begin
                        if (j == gap - 1) begin
                            cpu_idle();
                        end else begin
                            cpu_memrd = 1'($urandom_range(0, 1));
                            cpu_memwr = 1'($urandom_range(0, 1));
                            cpu_addr  = $urandom();
                        end
                        tick();
                    end
                end
            end
            cpu_idle();
            wait_idle(40);
            for (int i = 0; i < NW; i++) begin
                asserts++;
                if (i >= wr_addr_q.size() || wr_addr_q[i] !== BASE + 32'(4 * i) || wr_data_q[i] !== w[i]) begin
                    failures++;
                    $display("FAIL rand%0d_word%0d: got %0d writes, required data %h @%h",
                             s, i, wr_addr_q.size(), w[i], BASE + 32'(4 * i));
                end
            end
            asserts++;
            if (arb_err != 0 || ld_overrun !== 1'b0 || ld_words !== 16'(NW) || done_cnt != 1 || wr_addr_q.size() != NW) begin
                failures++;
                $display("FAIL rand%0d_status: got arb_err=%0d ovr=%b words=%0d done=%0d writes=%0d, required 0/0/%0d/1/%0d",
                         s, arb_err, ld_overrun, ld_words, done_cnt, wr_addr_q.size(), NW, NW);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cpu_idle();
        ld_start = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'd0;
        test_reset();
        test_basic_load();
        test_cpu_priority();
        test_overrun();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/dmem_load_arbiter.md
# dmem_load_arbiter

- Shares the single data-memory port between the CPU MEM stage and a UART boot-loader engine.
- The loader packs received UART bytes into 32-bit words and writes them to consecutive RAM addresses in cycles the CPU leaves idle.
- It sits between the pipeline's MEM stage and the data memory. Its rx inputs are driven by the UART receiver's byte/valid outputs.

## Interface
Parameters:
- LOAD_BASE, 32'h00000000, byte address of the first loaded word (word-aligned)
- LOAD_WORDS, 512, number of words per load session (1..65535)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_memrd  in  1  CPU read request
- cpu_memwr  in  1  CPU write request
- cpu_addr  in  32  CPU byte address
- cpu_wrdata  in  32  CPU write data
- cpu_rddata  out  32  read data returned to the CPU
- ld_start  in  1  single-cycle pulse that starts a load session
- rx_valid  in  1  single-cycle strobe: rx_byte valid
- rx_byte  in  8  received byte
- mem_rd  out  1  memory read enable
- mem_wr  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wrdata  out  32  memory write data
- mem_rddata  in  32  memory combinational read data
- ld_busy  out  1  a session is active
- ld_done  out  1  one-cycle pulse when the last word is committed
- ld_overrun  out  1  sticky: a word was dropped
- ld_words  out  16  words committed this session

## Operation
- **Arbitration (combinational, fixed priority):**
  - If cpu_memrd|cpu_memwr: the CPU is granted. mem_* = cpu_* and cpu_rddata = mem_rddata.
  - Else if a loader word is pending: mem_wr=1, mem_rd=0, mem_addr = LOAD_BASE + 4*ld_words, mem_wrdata = pending word. The commit takes effect at that clock edge.
  - Else all mem_* = 0.
  - cpu_rddata = 0 whenever the CPU is not granted.
- **FSM states:**
  - IDLE -> RUN on ld_start. On entry to RUN: ld_words, the byte index, pending and ld_overrun are cleared.
  - RUN: on each rx_valid, the byte is stored into shift word bits [8k+7:8k], where k = byte index 0..3 (little-endian). After byte 3, the assembled word moves to the pending register and the byte index wraps to 0.
  - RUN -> FLUSH when the word that brings assembled-word count to LOAD_WORDS is moved to pending.
  - FLUSH: rx_valid is ignored. On commit of the pending word -> IDLE, with ld_done pulsing for one cycle.
- **Commit:** clears pending and increments ld_words.
- **Overrun:** if a word completes while pending is still set, the new word is dropped, ld_overrun is set (sticky until the next ld_start), and the assembled-word count still advances.
- **Status:** ld_busy = (state != IDLE).
- **Ignored events:**
  - ld_start while busy.
  - rx_valid in IDLE.
  - rx_valid in the same cycle as ld_start; the session starts next cycle.
- **Simultaneous events:** a word completing in the same cycle as the pending word commits is not an overrun; pending is reloaded.

## Timing
- Reset values: all mem_* = 0, cpu_rddata = 0, ld_busy=0, ld_done=0, ld_overrun=0, ld_words=0, state IDLE, pending cleared.
- CPU path is zero-latency combinational, with no added stall.
- Loader latency: earliest commit is the edge after byte 3's rx_valid. It is deferred for as long as the CPU holds the port.
- Reset mid-session aborts the session immediately: no further writes, RAM contents already written are kept.
- Byte spacing ≥1 cycle. At 9600 bps the CPU must leave at least one idle cycle per ~29k cycles to avoid overrun.

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/RUN/FLUSH).
  - Constant MMIO addresses 32'h40000010 (digits), 32'h40000018 (UART TX), 32'h4000001C (UART RX), 32'h40000020 (UART ctrl).
  - A default load base.
- One natural sub-module, ld_word_packer: byte index, shift word, word_ready pulse.
- Arbiter mux and FSM stay in the top level.

## Test plan
- **Reset:** assert rst mid-stream -> all outputs 0, no mem_wr afterwards.
- **Basic load:** LOAD_WORDS=2, ld_start, bytes 78 56 34 12 EF BE AD DE with CPU idle -> writes 32'h12345678 @0x0 and 32'hDEADBEEF @0x4. ld_done pulses once, after the second commit; ld_words=2.
- **CPU priority:** keep cpu_memrd=1 to addr 0x8 for 10 cycles after a word completes -> mem_rd follows the CPU, and cpu_rddata equals mem_rddata throughout. The loader write appears in the first idle cycle.
- **Overrun:** hold cpu_memwr for 8 byte-times -> ld_overrun=1, the second word is absent from RAM, and ld_words increments only for committed words.
- **Ignored inputs:** rx_valid in IDLE, and ld_start while busy -> no state change and no writes.
- **Boundary:** word completes in the same cycle as the pending commit -> both words written, ld_overrun stays 0.
